gamma_lut_conv: RTL and testbench

- Parametrised successor of the per-channel gamma pre-processor. Sits between the capture/colour-decode stage and the line-buffer RAM write port.
- Applies a runtime-programmable lookup table per colour channel with a fixed pipeline latency.
- LUTs are double-banked. Host writes go to the shadow bank, and bank swaps and mode changes take effect only on a frame-start trigger, so the picture never tears mid-frame.

---
 rtl/gamma_lut_conv_if.sv | 40 ++++
 rtl/gamma_lut_conv.sv | 113 +++++++++++
 tb/tb_gamma_lut_conv.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gamma_lut_conv_if.sv
// Pixel stream and host LUT-programming signals for gamma_lut_conv.
// master = pixel source / host side, slave = converter side.
interface gamma_lut_conv_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 10
);
  // Host LUT programming
  logic                         gamma_mode;
  logic                         lut_wr_en;
  logic                         lut_wr_all;
  logic [3:0]                   lut_wr_chan;
  logic [DATA_W-1:0]            lut_wr_addr;
  logic [DATA_W-1:0]            lut_wr_data;
  logic                         lut_swap_req;
  logic                         lut_swap_pending;
  logic                         lut_wr_err;
  // Pixel input
  logic                         in_wren;
  logic [ADDR_W-1:0]            in_wraddr;
  logic [CHANNELS*DATA_W-1:0]   in_data;
  logic                         in_starttrigger;
  // Pixel output toward the line-buffer RAM
  logic                         wren;
  logic [ADDR_W-1:0]            wraddr;
  logic [CHANNELS*DATA_W-1:0]   wrdata;
  logic                         starttrigger;

  modport master (
    output gamma_mode, lut_wr_en, lut_wr_all, lut_wr_chan, lut_wr_addr, lut_wr_data,
           lut_swap_req, in_wren, in_wraddr, in_data, in_starttrigger,
    input  lut_swap_pending, lut_wr_err, wren, wraddr, wrdata, starttrigger
  );

  modport slave (
    input  gamma_mode, lut_wr_en, lut_wr_all, lut_wr_chan, lut_wr_addr, lut_wr_data,
           lut_swap_req, in_wren, in_wraddr, in_data, in_starttrigger,
    output lut_swap_pending, lut_wr_err, wren, wraddr, wrdata, starttrigger
  );
endinterface

// File: rtl/gamma_lut_conv.sv
// Per-channel gamma LUT converter with double-banked tables. Host writes go to the
// shadow bank; bank swap and mode change take effect only on a frame-start trigger.
// Fixed 2-clock latency: stage 1 = LUT read / bypass delay, stage 2 = output register.
module gamma_lut_conv #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 10
) (
  input logic              clock,
  input logic              reset_n,
  gamma_lut_conv_if.slave  bus
);

  localparam int unsigned PixW  = CHANNELS * DATA_W;
  localparam int unsigned Depth = 2 * (2 ** DATA_W);

  // Frame-level control state
  logic mode_q, bank_q, pend_q, err_q;
  logic mode_d, bank_d, pend_d, err_d;
  logic swap_exec, wr_bad_chan, wr_ok;

  // Stage 1
  logic              wren_s1_q, trig_s1_q, lutsel_s1_q;
  logic [ADDR_W-1:0] addr_s1_q;
  logic [PixW-1:0]   byp_s1_q;
  logic [PixW-1:0]   lut_pix;

  // Stage 2
  logic              wren_q, trig_q;
  logic [ADDR_W-1:0] wraddr_q;
  logic [PixW-1:0]   wrdata_q;

  // Effective mode/bank: the trigger pixel already sees the new values
  always_comb begin
    mode_d      = bus.in_starttrigger ? bus.gamma_mode : mode_q;
    bank_d      = bus.in_starttrigger ? (bank_q ^ pend_q) : bank_q;
    swap_exec   = bus.in_starttrigger & pend_q;
    wr_bad_chan = !bus.lut_wr_all && ({28'd0, bus.lut_wr_chan} >= CHANNELS);
    // swap_exec implies pend_q, kept explicit for readability
    wr_ok       = bus.lut_wr_en && !pend_q && !swap_exec && !wr_bad_chan;
    err_d       = bus.lut_wr_en && !wr_ok;
    // A request on the swap edge itself is swallowed; the swap wins
    pend_d      = swap_exec ? 1'b0 : (pend_q | bus.lut_swap_req);
  end

  // Control registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      bank_q <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      bank_q <= bank_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // Per-channel LUT RAM: write port on shadow bank, read port on effective bank
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] sample;
    logic              wr_sel;

    assign sample = bus.in_data[(CHANNELS-1-c)*DATA_W +: DATA_W];
    assign wr_sel = wr_ok && (bus.lut_wr_all || (bus.lut_wr_chan == 4'(c)));
    assign lut_pix[(CHANNELS-1-c)*DATA_W +: DATA_W] = rd_q;

    // RAM contents are intentionally not reset
    always_ff @(posedge clock) begin
      if (wr_sel) begin
        mem[{~bank_q, bus.lut_wr_addr}] <= bus.lut_wr_data;
      end
      rd_q <= mem[{bank_d, sample}];
    end
  end

  // Pipeline registers; reset flushes both stages so no stale pixel emerges
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wren_s1_q   <= 1'b0;
      trig_s1_q   <= 1'b0;
      lutsel_s1_q <= 1'b0;
      addr_s1_q   <= '0;
      byp_s1_q    <= '0;
      wren_q      <= 1'b0;
      trig_q      <= 1'b0;
      wraddr_q    <= '0;
      wrdata_q    <= '0;
    end else begin
      wren_s1_q   <= bus.in_wren;
      trig_s1_q   <= bus.in_starttrigger;
      lutsel_s1_q <= mode_d;
      addr_s1_q   <= bus.in_wraddr;
      byp_s1_q    <= bus.in_data;
      wren_q      <= wren_s1_q;
      trig_q      <= trig_s1_q;
      wraddr_q    <= addr_s1_q;
      wrdata_q    <= lutsel_s1_q ? lut_pix : byp_s1_q;
    end
  end

  assign bus.wren             = wren_q;
  assign bus.wraddr           = wraddr_q;
  assign bus.wrdata           = wrdata_q;
  assign bus.starttrigger     = trig_q;
  assign bus.lut_swap_pending = pend_q;
  assign bus.lut_wr_err       = err_q;

endmodule

// File: tb/tb_gamma_lut_conv.sv
// Directed bench for gamma_lut_conv. Expected pixel outputs are pushed to a scoreboard
// queue as each input is driven and popped once the 2-cycle latency has elapsed.
module tb_gamma_lut_conv;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  gamma_lut_conv_if #(.CHANNELS(3), .DATA_W(8), .ADDR_W(10)) bus ();

  gamma_lut_conv #(.CHANNELS(3), .DATA_W(8), .ADDR_W(10)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        chk;
    logic        we;
    logic [9:0]  a;
    logic [23:0] d;
    logic        trig;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock with a pixel on the input; compares the output of the pixel one step older
  task automatic step(input logic we, input logic [9:0] a, input logic [23:0] d,
                      input logic trig, input logic chk, input logic [23:0] exp_d);
    exp_t e;
    bus.in_wren         = we;
    bus.in_wraddr       = a;
    bus.in_data         = d;
    bus.in_starttrigger = trig;
    sb.push_back('{chk: chk, we: we, a: a, d: exp_d, trig: trig});
    @(posedge clock);
    #1;
    bus.lut_swap_req = 1'b0;
    bus.lut_wr_en    = 1'b0;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      if (e.chk) begin
        check("pixel", {bus.wren, bus.wraddr, bus.wrdata, bus.starttrigger},
              {e.we, e.a, e.d, e.trig});
      end
    end
  endtask

  task automatic host_wr(input logic all, input logic [3:0] chan, input logic [7:0] addr,
                         input logic [7:0] data, input logic exp_err);
    bus.lut_wr_en   = 1'b1;
    bus.lut_wr_all  = all;
    bus.lut_wr_chan = chan;
    bus.lut_wr_addr = addr;
    bus.lut_wr_data = data;
    step(1'b0, 10'h0, 24'h0, 1'b0, 1'b0, 24'h0);
    check("wr_err", {35'd0, bus.lut_wr_err}, {35'd0, exp_err});
  endtask

  // Reset for n cycles with a live pixel on the input, then release
  task automatic do_reset(input int n);
    sb.delete();
    reset_n             = 1'b0;
    bus.in_wren         = 1'b1;
    bus.in_wraddr       = 10'h3FF;
    bus.in_data         = 24'h202020;
    bus.in_starttrigger = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
    check("rst_out", {bus.wren, bus.wraddr, bus.wrdata, bus.starttrigger}, 36'd0);
    check("rst_ctl", {34'd0, bus.lut_swap_pending, bus.lut_wr_err}, 36'd0);
    reset_n = 1'b1;
    // Stage 1 was flushed by reset: its output must be all zeros
    sb.push_back('{chk: 1'b1, we: 1'b0, a: 10'h0, d: 24'h0, trig: 1'b0});
  endtask

  initial begin
    bus.gamma_mode      = 1'b0;
    bus.lut_wr_en       = 1'b0;
    bus.lut_wr_all      = 1'b0;
    bus.lut_wr_chan     = 4'd0;
    bus.lut_wr_addr     = 8'd0;
    bus.lut_wr_data     = 8'd0;
    bus.lut_swap_req    = 1'b0;
    bus.in_wren         = 1'b0;
    bus.in_wraddr       = 10'd0;
    bus.in_data         = 24'd0;
    bus.in_starttrigger = 1'b0;

    do_reset(2);

    // Bypass pass-through with 2-cycle latency
    step(1'b1, 10'h005, 24'h102030, 1'b0, 1'b1, 24'h102030);
    step(1'b0, 10'h000, 24'h000000, 1'b0, 1'b1, 24'h000000);

    // Fill shadow bank 1 with an inverting curve on all channels
    for (int i = 0; i < 256; i++) begin
      host_wr(1'b1, 4'd0, 8'(i), 8'(255 - i), 1'b0);
    end

    // Request swap, then attempt a write while pending: must be rejected
    bus.gamma_mode   = 1'b1;
    bus.lut_swap_req = 1'b1;
    step(1'b0, 10'h0, 24'h0, 1'b0, 1'b0, 24'h0);
    check("pend_set", {35'd0, bus.lut_swap_pending}, 36'd1);
    host_wr(1'b1, 4'd0, 8'h10, 8'hAA, 1'b1);
    step(1'b0, 10'h0, 24'h0, 1'b0, 1'b0, 24'h0);
    check("err_pulse1", {35'd0, bus.lut_wr_err}, 36'd0);

    // Frame start: swap and LUT mode apply to the trigger pixel itself
    step(1'b1, 10'h003, 24'h00FF80, 1'b1, 1'b1, 24'hFF007F);
    check("pend_clr", {35'd0, bus.lut_swap_pending}, 36'd0);
    step(1'b1, 10'h004, 24'h101010, 1'b0, 1'b1, 24'hEFEFEF);

    // Shadow is now bank 0: program entry 0x20 per channel, then an illegal channel
    host_wr(1'b0, 4'd0, 8'h20, 8'h11, 1'b0);
    host_wr(1'b0, 4'd1, 8'h20, 8'h22, 1'b0);
    host_wr(1'b0, 4'd2, 8'h20, 8'h33, 1'b0);
    host_wr(1'b0, 4'd5, 8'h20, 8'h55, 1'b1);
    step(1'b0, 10'h0, 24'h0, 1'b0, 1'b0, 24'h0);
    check("err_pulse2", {35'd0, bus.lut_wr_err}, 36'd0);

    // Mode drop without trigger has no effect until the next frame start
    bus.gamma_mode = 1'b0;
    step(1'b1, 10'h008, 24'h000000, 1'b0, 1'b1, 24'hFFFFFF);
    step(1'b1, 10'h009, 24'h123456, 1'b1, 1'b1, 24'h123456);

    // Swap request coincident with trigger waits for the following trigger
    bus.gamma_mode   = 1'b1;
    bus.lut_swap_req = 1'b1;
    step(1'b1, 10'h00A, 24'h010101, 1'b1, 1'b1, 24'hFEFEFE);
    check("pend_late", {35'd0, bus.lut_swap_pending}, 36'd1);
    step(1'b1, 10'h00B, 24'h202020, 1'b0, 1'b1, 24'hDFDFDF);
    step(1'b1, 10'h00C, 24'h202020, 1'b1, 1'b1, 24'h112233);
    check("pend_clr2", {35'd0, bus.lut_swap_pending}, 36'd0);

    // Mid-stream reset: outputs clear, mode back to bypass, active bank back to 0
    step(1'b1, 10'h00D, 24'hABCDEF, 1'b0, 1'b0, 24'h0);
    do_reset(1);
    step(1'b1, 10'h00E, 24'h202020, 1'b0, 1'b1, 24'h202020);
    step(1'b1, 10'h00F, 24'h202020, 1'b1, 1'b1, 24'h112233);
    step(1'b0, 10'h000, 24'h000000, 1'b0, 1'b0, 24'h0);
    step(1'b0, 10'h000, 24'h000000, 1'b0, 1'b0, 24'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
